// File: rtl/uart_cmd_parser_if.sv
// Byte-input / register-write bundle between the UART receiver, the command parser and the register file.
interface uart_cmd_parser_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx_done, rx_data,
    output wr_en, wr_addr, wr_data, frame_ok, frame_err, busy
  );

  modport slave (
    output rx_done, rx_data,
    input  wr_en, wr_addr, wr_data, frame_ok, frame_err, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles HDR/ADDR/LEN/DATA/CHK frames from UART bytes and replays verified payloads as register writes.
// Writes start the cycle after the CHK byte; bad, oversize or stalled frames are dropped with a frame_err pulse.
module uart_cmd_parser #(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         UART_BPS      = 9600,
  parameter int         TIMEOUT_BYTES = 3,
  parameter logic [7:0] HDR           = 8'hA5,
  parameter int         MAX_LEN       = 8
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  uart_cmd_parser_if.master bus
);
  localparam int            TMO       = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS);
  localparam int            CW        = ($clog2(TMO + 1) > 24) ? $clog2(TMO + 1) : 24;
  // Counter reads 0 the cycle after a strobe, so the error lands exactly TMO cycles after it.
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 2);
  localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_WRITE
  } state_t;

  state_t        state;
  logic          rx_done_q;
  logic          byte_stb;
  logic [7:0]    addr;
  logic [7:0]    len;
  logic [7:0]    acc;
  logic [7:0]    idx;
  logic [CW-1:0] tmo_cnt;
  logic [7:0]    pbuf [MAX_LEN];

  assign byte_stb = bus.rx_done & ~rx_done_q;

  always_ff @(posedge I_clk) begin
    if (state == S_DATA && byte_stb)
      pbuf[idx[IW-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= S_IDLE;
      rx_done_q     <= 1'b0;
      addr          <= '0;
      len           <= '0;
      acc           <= '0;
      idx           <= '0;
      tmo_cnt       <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      rx_done_q     <= bus.rx_done;
      bus.wr_en     <= 1'b0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (byte_stb && bus.rx_data == HDR) begin
            state    <= S_ADDR;
            bus.busy <= 1'b1;
          end
        end
        S_WRITE: begin
          tmo_cnt <= '0;
          if (idx == len) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else begin
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= addr + idx;
            bus.wr_data  <= pbuf[idx[IW-1:0]];
            bus.frame_ok <= (idx == len - 8'd1);
            idx          <= idx + 8'd1;
          end
        end
        default: begin
          // A strobe in the expiry cycle wins over the timeout.
          if (byte_stb) begin
            tmo_cnt <= '0;
            case (state)
              S_ADDR: begin
                addr  <= bus.rx_data;
                acc   <= bus.rx_data;
                state <= S_LEN;
              end
              S_LEN: begin
                if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                  bus.frame_err <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= S_IDLE;
                end else begin
                  len   <= bus.rx_data;
                  acc   <= acc + bus.rx_data;
                  idx   <= '0;
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                acc <= acc + bus.rx_data;
                idx <= idx + 8'd1;
                if (idx == len - 8'd1)
                  state <= S_CHK;
              end
              S_CHK: begin
                if (bus.rx_data == acc) begin
                  bus.wr_en    <= 1'b1;
                  bus.wr_addr  <= addr;
                  bus.wr_data  <= pbuf[0];
                  bus.frame_ok <= (len == 8'd1);
                  idx          <= 8'd1;
                  state        <= S_WRITE;
                end else begin
                  bus.frame_err <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= S_IDLE;
                end
              end
              default: ;
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt       <= '0;
            bus.frame_err <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frames for uart_cmd_parser, checked against a frame-level write model.
module tb_uart_cmd_parser;
  localparam int         CLK_FREQ = 960000;
  localparam int         UART_BPS = 9600;
  localparam int         TBYTES   = 3;
  localparam logic [7:0] HDR      = 8'hA5;
  localparam int         MAX_LEN  = 8;
  localparam int         TMO      = TBYTES * 10 * (CLK_FREQ / UART_BPS);

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  d;
    logic [31:0] cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] cyc = 0;
  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .TIMEOUT_BYTES(TBYTES),
    .HDR(HDR), .MAX_LEN(MAX_LEN)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t         wlog [$];
  logic [31:0] olog [$];
  logic [31:0] elog [$];

  always @(negedge clk) begin
    if (bus.wr_en)     wlog.push_back({bus.wr_addr, bus.wr_data, cyc});
    if (bus.frame_ok)  olog.push_back(cyc);
    if (bus.frame_err) elog.push_back(cyc);
  end

  int n_chk = 0;
  int n_pass = 0;
  int last_stb, chk_stb, wb, ob, eb;
  logic [7:0] fd [MAX_LEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic mark();
    wb = wlog.size();
    ob = olog.size();
    eb = elog.size();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    last_stb = cyc;
    repeat (hold) @(posedge clk);
    #1 bus.rx_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input int n, input logic [7:0] xr,
                            input int hold, input int gap);
    int s;
    s = a + n;
    for (int i = 0; i < n; i++) s += fd[i];
    send_byte(HDR, hold, gap);
    send_byte(a, hold, gap);
    send_byte(8'(n), hold, gap);
    for (int i = 0; i < n; i++) send_byte(fd[i], hold, gap);
    send_byte(8'(s % 256) ^ xr, hold, gap);
    chk_stb = last_stb;
  endtask

  // Expected: n writes (a+i mod 256, fd[i]) at chk_stb+1+i and frame_ok at chk_stb+n, or one error.
  task automatic check_frame(input string tag, input logic [7:0] a, input int n, input bit good);
    logic [7:0] ea;
    repeat (MAX_LEN + 4) @(posedge clk); #1;
    check({tag, ":nwr"}, wlog.size() - wb, good ? n : 0);
    if (good && wlog.size() - wb == n) begin
      for (int i = 0; i < n; i++) begin
        ea = 8'((a + i) % 256);
        check({tag, ":addr"}, wlog[wb+i].a, ea);
        check({tag, ":data"}, wlog[wb+i].d, fd[i]);
        check({tag, ":wcyc"}, wlog[wb+i].cyc - chk_stb, 1 + i);
      end
    end
    check({tag, ":nok"}, olog.size() - ob, good ? 1 : 0);
    if (good && olog.size() > ob) check({tag, ":okcyc"}, olog[ob] - chk_stb, n);
    check({tag, ":nerr"}, elog.size() - eb, good ? 0 : 1);
    if (!good && elog.size() > eb) check({tag, ":errcyc"}, elog[eb] - chk_stb, 1);
    check({tag, ":busy"}, bus.busy, 1'b0);
    mark();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ":wr_en"}, bus.wr_en, 1'b0);
    check({tag, ":wr_addr"}, bus.wr_addr, 8'h00);
    check({tag, ":wr_data"}, bus.wr_data, 8'h00);
    check({tag, ":frame_ok"}, bus.frame_ok, 1'b0);
    check({tag, ":frame_err"}, bus.frame_err, 1'b0);
    check({tag, ":busy"}, bus.busy, 1'b0);
  endtask

  task automatic bad_len(input string tag, input logic [7:0] lb);
    int stb;
    mark();
    send_byte(HDR, 1, 0);
    send_byte(8'h10, 1, 0);
    send_byte(lb, 1, 0);
    stb = last_stb;
    repeat (4) @(posedge clk); #1;
    check({tag, ":nerr"}, elog.size() - eb, 1);
    if (elog.size() > eb) check({tag, ":errcyc"}, elog[eb] - stb, 1);
    check({tag, ":nwr"}, wlog.size() - wb, 0);
    check({tag, ":busy"}, bus.busy, 1'b0);
    mark();
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, stb, n, hold, gap;
    logic [7:0] a, xr;
    bit good;

    rst_n = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    mark();

    fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33;
    send_frame(8'h10, 3, 8'h00, 1, 0);
    check_frame("basic", 8'h10, 3, 1'b1);

    fd[0] = 8'h01; fd[1] = 8'h02; fd[2] = 8'h03;
    send_frame(8'hFE, 3, 8'h00, 1, 1);
    check_frame("wrap", 8'hFE, 3, 1'b1);

    fd[0] = 8'hAA; fd[1] = 8'hBB;
    send_frame(8'h10, 2, 8'h77, 1, 0);
    check_frame("badchk", 8'h10, 2, 1'b0);
    fd[0] = 8'h5C;
    send_frame(8'h33, 1, 8'h00, 2, 0);
    check_frame("after_bad", 8'h33, 1, 1'b1);

    bad_len("len0", 8'h00);
    bad_len("len9", 8'h09);

    // Silent after one payload byte.
    mark();
    send_byte(HDR, 1, 0);
    send_byte(8'h10, 1, 0);
    send_byte(8'h02, 1, 0);
    send_byte(8'hAA, 1, 0);
    stb = last_stb;
    k = 0;
    while (elog.size() == eb && k < TMO + 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("tmo:nerr", elog.size() - eb, 1);
    if (elog.size() > eb) check("tmo:cyc", elog[eb] - stb, TMO);
    check("tmo:nwr", wlog.size() - wb, 0);
    check("tmo:busy", bus.busy, 1'b0);
    mark();
    fd[0] = 8'h9E; fd[1] = 8'h01;
    send_frame(8'h70, 2, 8'h00, 1, 0);
    check_frame("post_tmo", 8'h70, 2, 1'b1);

    // Long rx_done pulses with stray bytes ahead of the header.
    send_byte(8'h3C, 2600, 0);
    send_byte(8'h5A, 2600, 0);
    fd[0] = 8'h5A; fd[1] = 8'hC3;
    send_frame(8'h20, 2, 8'h00, 2600, 0);
    check_frame("hold", 8'h20, 2, 1'b1);

    // Header arrives the first cycle after WRITE ends.
    fd[0] = 8'h12; fd[1] = 8'h34;
    send_frame(8'h40, 2, 8'h00, 1, 1);
    fd[0] = 8'h56;
    send_frame(8'h50, 1, 8'h00, 1, 0);
    repeat (MAX_LEN + 4) @(posedge clk); #1;
    check("b2b:nwr", wlog.size() - wb, 3);
    check("b2b:nok", olog.size() - ob, 2);
    check("b2b:nerr", elog.size() - eb, 0);
    if (wlog.size() - wb == 3) begin
      check("b2b:addr", wlog[wb+2].a, 8'h50);
      check("b2b:data", wlog[wb+2].d, 8'h56);
    end
    mark();

    for (int f = 0; f < 20; f++) begin
      a = 8'($urandom);
      n = $urandom_range(1, MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) fd[i] = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      xr = good ? 8'h00 : 8'($urandom_range(1, 255));
      hold = $urandom_range(1, 3);
      gap = $urandom_range(0, 2);
      send_frame(a, n, xr, hold, gap);
      check_frame("rand", a, n, good);
    end

    // Reset during WRITE: two writes have gone out, nothing more may follow.
    for (int i = 0; i < MAX_LEN; i++) fd[i] = 8'($urandom);
    send_frame(8'hC0, MAX_LEN, 8'h00, 1, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_wr");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    check("rst_wr:nwr", wlog.size() - wb, 2);
    check("rst_wr:nok", olog.size() - ob, 0);
    check("rst_wr:nerr", elog.size() - eb, 0);
    mark();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
